pb_code_lock: RTL and testbench



---
 rtl/pb_lock_pkg.sv | 21 ++
 rtl/pb_code_lock.sv | 179 +++++++++++++++++
 tb/tb_pb_code_lock.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pb_lock_pkg.sv
// Shared types and constants for the push-button combination lock.
package pb_lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_LOCKOUT = 3'd3
    } state_e;

    localparam logic [3:0] DIGIT_NONE    = 4'hf;
    localparam logic [3:0] DIGIT_INVALID = 4'he;

    // Digit d of the switch code lives in bits [2d+1:2d].
    function automatic logic [1:0] code_digit(input logic [7:0] code, input logic [1:0] idx);
        logic [7:0] shifted;
        shifted = code >> {idx, 1'b0};
        return shifted[1:0];
    endfunction

endpackage

// File: rtl/pb_code_lock.sv
// Four-press combination lock with timed open window, entry timeout and error lockout.
module pb_code_lock
    import pb_lock_pkg::*;
#(
    parameter int unsigned MAX_ERRORS       = 3,
    parameter int unsigned OPEN_MS          = 5000,
    parameter int unsigned LOCKOUT_MS       = 10000,
    parameter int unsigned ENTRY_TIMEOUT_MS = 3000
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       tick_1ms_i,
    input  logic [3:0] pb_pulse_i,
    input  logic [7:0] code_i,
    output logic [2:0] state_o,
    output logic       unlocked_o,
    output logic       lockout_o,
    output logic [2:0] entry_count_o,
    output logic [1:0] error_count_o,
    output logic [3:0] digit_o
);

    localparam logic [15:0] OpenLast    = 16'(OPEN_MS - 1);
    localparam logic [15:0] LockoutLast = 16'(LOCKOUT_MS - 1);
    localparam logic [15:0] EntryLast   = 16'(ENTRY_TIMEOUT_MS - 1);
    localparam logic [1:0]  MaxErr      = 2'(MAX_ERRORS);

    state_e      state_q, state_d;
    logic [2:0]  entry_q, entry_d;
    logic [1:0]  err_q, err_d;
    logic [3:0]  digit_q, digit_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  code_q, code_d;
    logic        mism_q, mism_d;
    logic        unlocked_q, unlocked_d;
    logic        lockout_q, lockout_d;

    logic        press_any, press_valid, accepted, expire, mism_new;
    logic [1:0]  press_idx, err_inc;
    logic [3:0]  press_digit;
    logic [15:0] timer_last;

    always_comb begin
        press_any   = |pb_pulse_i;
        press_valid = $onehot(pb_pulse_i);
        case (pb_pulse_i)
            4'b0010: press_idx = 2'd1;
            4'b0100: press_idx = 2'd2;
            4'b1000: press_idx = 2'd3;
            default: press_idx = 2'd0;
        endcase
        press_digit = press_valid ? {2'b00, press_idx} : DIGIT_INVALID;

        case (state_q)
            S_OPEN:    timer_last = OpenLast;
            S_LOCKOUT: timer_last = LockoutLast;
            default:   timer_last = EntryLast;
        endcase
        expire  = tick_1ms_i && (timer_q == timer_last);
        err_inc = (err_q == MaxErr) ? err_q : err_q + 2'd1;
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        err_d    = err_q;
        digit_d  = digit_q;
        code_d   = code_q;
        mism_d   = mism_q;
        accepted = 1'b0;
        mism_new = mism_q;

        case (state_q)
            S_IDLE: begin
                if (press_any) begin
                    accepted = 1'b1;
                    state_d  = S_ENTRY;
                    entry_d  = 3'd1;
                    digit_d  = press_digit;
                    code_d   = code_i;
                    mism_d   = !press_valid || (press_idx != code_digit(code_i, 2'd0));
                end
            end
            S_ENTRY: begin
                if (press_any) begin
                    accepted = 1'b1;
                    entry_d  = entry_q + 3'd1;
                    digit_d  = press_digit;
                    mism_new = mism_q || !press_valid
                               || (press_idx != code_digit(code_q, entry_q[1:0]));
                    mism_d   = mism_new;
                    if (entry_q == 3'd3) begin
                        if (!mism_new) begin
                            state_d = S_OPEN;
                            err_d   = 2'd0;
                        end else begin
                            err_d   = err_inc;
                            entry_d = 3'd0;
                            if (err_inc == MaxErr) begin
                                state_d = S_LOCKOUT;
                            end else begin
                                state_d = S_IDLE;
                                digit_d = DIGIT_NONE;
                            end
                        end
                    end
                end else if (expire) begin
                    state_d = S_IDLE;
                    entry_d = 3'd0;
                    digit_d = DIGIT_NONE;
                end
            end
            S_OPEN: begin
                if (press_any || expire) begin
                    state_d = S_IDLE;
                    entry_d = 3'd0;
                    digit_d = DIGIT_NONE;
                end
            end
            S_LOCKOUT: begin
                if (expire) begin
                    state_d = S_IDLE;
                    err_d   = 2'd0;
                    entry_d = 3'd0;
                    digit_d = DIGIT_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                entry_d = 3'd0;
                digit_d = DIGIT_NONE;
            end
        endcase

        // Idle has no timeout, so the timer only runs in the timed states.
        if ((state_d != state_q) || accepted) begin
            timer_d = 16'd0;
        end else if (tick_1ms_i && (state_q != S_IDLE)) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end

        unlocked_d = (state_d == S_OPEN);
        lockout_d  = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            entry_q    <= 3'd0;
            err_q      <= 2'd0;
            digit_q    <= DIGIT_NONE;
            timer_q    <= 16'd0;
            code_q     <= 8'd0;
            mism_q     <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            err_q      <= err_d;
            digit_q    <= digit_d;
            timer_q    <= timer_d;
            code_q     <= code_d;
            mism_q     <= mism_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
        end
    end

    assign state_o       = state_q;
    assign unlocked_o    = unlocked_q;
    assign lockout_o     = lockout_q;
    assign entry_count_o = entry_q;
    assign error_count_o = err_q;
    assign digit_o       = digit_q;

endmodule

// File: tb/tb_pb_code_lock.sv
// Directed bench for pb_code_lock: open, lockout, timeout, latched code, invalid press, reset.
module tb_pb_code_lock;

    logic       clk;
    logic       resetn;
    logic       tick;
    logic [3:0] pb;
    logic [7:0] code;
    logic [2:0] state;
    logic       unlocked;
    logic       lockout;
    logic [2:0] entry_count;
    logic [1:0] error_count;
    logic [3:0] digit;

    int errors = 0;
    int checks = 0;

    pb_code_lock dut (
        .CLOCK_50_I    (clk),
        .resetn        (resetn),
        .tick_1ms_i    (tick),
        .pb_pulse_i    (pb),
        .code_i        (code),
        .state_o       (state),
        .unlocked_o    (unlocked),
        .lockout_o     (lockout),
        .entry_count_o (entry_count),
        .error_count_o (error_count),
        .digit_o       (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] v);
        pb = v;
        @(posedge clk);
        #1;
        pb = 4'b0000;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fail_entry();
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b0100);
    endtask

    initial begin
        resetn = 1'b0;
        tick   = 1'b0;
        pb     = 4'b0000;
        code   = 8'b11_10_01_00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_unlocked", 16'(unlocked), 16'd0);
        chk("rst_lockout", 16'(lockout), 16'd0);
        chk("rst_entry", 16'(entry_count), 16'd0);
        chk("rst_err", 16'(error_count), 16'd0);
        chk("rst_digit", 16'(digit), 16'hf);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Correct entry opens, then the open window times out.
        press(4'b0001);
        chk("e1_state", 16'(state), 16'd1);
        chk("e1_entry", 16'(entry_count), 16'd1);
        chk("e1_digit", 16'(digit), 16'd0);
        ticks(3);
        press(4'b0010);
        chk("e2_entry", 16'(entry_count), 16'd2);
        chk("e2_digit", 16'(digit), 16'd1);
        ticks(3);
        press(4'b0100);
        ticks(3);
        press(4'b1000);
        chk("open_state", 16'(state), 16'd2);
        chk("open_unlocked", 16'(unlocked), 16'd1);
        chk("open_err", 16'(error_count), 16'd0);
        chk("open_digit", 16'(digit), 16'd3);
        ticks(4999);
        chk("open_4999", 16'(state), 16'd2);
        ticks(1);
        chk("open_expired", 16'(state), 16'd0);
        chk("open_exp_unl", 16'(unlocked), 16'd0);
        chk("open_exp_entry", 16'(entry_count), 16'd0);
        chk("open_exp_digit", 16'(digit), 16'hf);

        // Three wrong entries force lockout; lockout expires and clears the error count.
        fail_entry();
        chk("fail1_err", 16'(error_count), 16'd1);
        chk("fail1_state", 16'(state), 16'd0);
        fail_entry();
        chk("fail2_err", 16'(error_count), 16'd2);
        fail_entry();
        chk("lock_state", 16'(state), 16'd3);
        chk("lock_flag", 16'(lockout), 16'd1);
        chk("lock_err", 16'(error_count), 16'd3);
        press(4'b0001);
        chk("lock_press_entry", 16'(entry_count), 16'd0);
        chk("lock_press_state", 16'(state), 16'd3);
        ticks(9999);
        chk("lock_9999", 16'(state), 16'd3);
        ticks(1);
        chk("lock_exp_state", 16'(state), 16'd0);
        chk("lock_exp_flag", 16'(lockout), 16'd0);
        chk("lock_exp_err", 16'(error_count), 16'd0);

        // Entry timeout discards the partial entry but keeps the error count.
        fail_entry();
        press(4'b0001);
        press(4'b0010);
        ticks(2999);
        chk("to_2999_state", 16'(state), 16'd1);
        chk("to_2999_entry", 16'(entry_count), 16'd2);
        ticks(1);
        chk("to_state", 16'(state), 16'd0);
        chk("to_entry", 16'(entry_count), 16'd0);
        chk("to_err", 16'(error_count), 16'd1);

        // Switches changed mid-entry: the code latched on the first press still opens.
        press(4'b0001);
        code = 8'h00;
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        chk("latch_state", 16'(state), 16'd2);
        chk("latch_err", 16'(error_count), 16'd0);
        press(4'b0001);
        chk("relock_state", 16'(state), 16'd0);
        chk("relock_unl", 16'(unlocked), 16'd0);
        chk("relock_entry", 16'(entry_count), 16'd0);
        code = 8'b11_10_01_00;

        // Two buttons at once count as a press that can never match.
        press(4'b0001);
        press(4'b0010);
        press(4'b0011);
        chk("inv_digit", 16'(digit), 16'he);
        chk("inv_entry", 16'(entry_count), 16'd3);
        press(4'b1000);
        chk("inv_state", 16'(state), 16'd0);
        chk("inv_err", 16'(error_count), 16'd1);

        // Press coinciding with the expiring tick wins and restarts the timer.
        press(4'b0001);
        ticks(2999);
        pb   = 4'b0010;
        tick = 1'b1;
        @(posedge clk);
        #1;
        pb   = 4'b0000;
        tick = 1'b0;
        chk("coinc_state", 16'(state), 16'd1);
        chk("coinc_entry", 16'(entry_count), 16'd2);
        ticks(2999);
        chk("coinc_restart", 16'(state), 16'd1);
        press(4'b0100);
        chk("coinc_entry3", 16'(entry_count), 16'd3);

        // Asynchronous reset mid-entry.
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_state", 16'(state), 16'd0);
        chk("mid_rst_entry", 16'(entry_count), 16'd0);
        chk("mid_rst_err", 16'(error_count), 16'd0);
        chk("mid_rst_digit", 16'(digit), 16'hf);
        chk("mid_rst_unl", 16'(unlocked), 16'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_state", 16'(state), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
